// File: rtl/wb_bus_ctl.sv
// Shares one classic Wishbone bus between the fetch (I) and data (D) ports.
// Round-robin arbitration, single cycles, no-ack timeout, registered read data.
module wb_bus_ctl #(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_done,
  output logic        i_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic        d_err,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  output logic        pause_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_t          r_state;
  state_t          w_next;
  logic            r_last_d;
  logic            r_gnt_d;
  logic [31:0]     r_adr;
  logic [31:0]     r_dat;
  logic            r_we;
  logic [3:0]      r_sel;
  logic [TO_W-1:0] r_cnt;
  logic            r_err;
  logic [31:0]     r_i_rdata;
  logic [31:0]     r_d_rdata;
  logic            w_grant;
  logic            w_pick_d;
  logic            w_to;

  assign w_to = (r_cnt == TO_LAST);

  always_comb begin
    w_next   = r_state;
    w_grant  = 1'b0;
    w_pick_d = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (i_req | d_req) begin
          w_grant  = 1'b1;
          // D wins a tie unless it was the last port served
          w_pick_d = d_req & (~i_req | ~r_last_d);
          w_next   = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (wb_err_i | wb_ack_i | w_to)
          w_next = S_RESP;
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_last_d  <= 1'b0;
      r_gnt_d   <= 1'b0;
      r_adr     <= '0;
      r_dat     <= '0;
      r_we      <= 1'b0;
      r_sel     <= '0;
      r_cnt     <= '0;
      r_err     <= 1'b0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
    end else begin
      r_state <= w_next;
      if (w_grant) begin
        r_gnt_d  <= w_pick_d;
        r_last_d <= w_pick_d;
        r_adr    <= w_pick_d ? d_addr : i_addr;
        r_dat    <= w_pick_d ? d_wdata : 32'h0;
        r_we     <= w_pick_d & d_we;
        r_sel    <= w_pick_d ? d_be : 4'hF;
        r_cnt    <= '0;
        r_err    <= 1'b0;
      end
      if (r_state == S_ACCESS) begin
        if (wb_err_i) begin
          r_err <= 1'b1;
        end else if (wb_ack_i) begin
          if (!r_we) begin
            if (r_gnt_d) r_d_rdata <= wb_dat_i;
            else         r_i_rdata <= wb_dat_i;
          end
        end else if (w_to) begin
          r_err <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign wb_cyc_o = (r_state == S_ACCESS);
  assign wb_stb_o = (r_state == S_ACCESS);
  assign wb_we_o  = r_we;
  assign wb_sel_o = r_sel;
  assign wb_adr_o = r_adr;
  assign wb_dat_o = r_dat;

  assign i_done  = (r_state == S_RESP) & ~r_gnt_d;
  assign d_done  = (r_state == S_RESP) & r_gnt_d;
  assign i_err   = i_done & r_err;
  assign d_err   = d_done & r_err;
  assign i_rdata = r_i_rdata;
  assign d_rdata = r_d_rdata;

  assign pause_o = (i_req & ~i_done) | (d_req & ~d_done);

endmodule

// File: tb/tb_wb_bus_ctl.sv
// Scoreboard bench for wb_bus_ctl: directed accesses against a
// configurable Wishbone slave model, completions checked by a monitor.
module tb_wb_bus_ctl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic [31:0] i_rdata;
  logic        i_done;
  logic        i_err;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [3:0]  d_be = '0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [31:0] d_rdata;
  logic        d_done;
  logic        d_err;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i = '0;
  logic        wb_ack_i = 1'b0;
  logic        wb_err_i = 1'b0;
  logic        pause_o;

  wb_bus_ctl #(
    .TIMEOUT(4),
    .TO_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_req(i_req),
    .i_addr(i_addr),
    .i_rdata(i_rdata),
    .i_done(i_done),
    .i_err(i_err),
    .d_req(d_req),
    .d_we(d_we),
    .d_be(d_be),
    .d_addr(d_addr),
    .d_wdata(d_wdata),
    .d_rdata(d_rdata),
    .d_done(d_done),
    .d_err(d_err),
    .wb_cyc_o(wb_cyc_o),
    .wb_stb_o(wb_stb_o),
    .wb_we_o(wb_we_o),
    .wb_sel_o(wb_sel_o),
    .wb_adr_o(wb_adr_o),
    .wb_dat_o(wb_dat_o),
    .wb_dat_i(wb_dat_i),
    .wb_ack_i(wb_ack_i),
    .wb_err_i(wb_err_i),
    .pause_o(pause_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        pd;
    logic        err;
    logic [31:0] rd;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_i = '0;
  logic [31:0] exp_d = '0;

  // slave model configuration: mode 0=ack 1=silent 2=ack+err 3=err
  int          s_wait = 0;
  int          s_mode = 0;
  int          s_cnt = 0;
  int          s_last = 0;
  logic [31:0] s_data = '0;
  logic [31:0] s_adr = '0;
  logic [31:0] s_dat = '0;
  logic [3:0]  s_sel = '0;
  logic        s_we = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (wb_stb_o) begin
        s_cnt++;
        s_sel = wb_sel_o;
        s_we  = wb_we_o;
        s_adr = wb_adr_o;
        s_dat = wb_dat_o;
      end else begin
        if (s_cnt != 0) s_last = s_cnt;
        s_cnt = 0;
      end
      wb_ack_i = wb_stb_o && s_cnt > s_wait && (s_mode == 0 || s_mode == 2);
      wb_err_i = wb_stb_o && s_cnt > s_wait && (s_mode >= 2);
      wb_dat_i = wb_ack_i ? s_data : 32'hFFFF_FFFF;
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (i_done || d_done) begin
        chk("one_done", {31'b0, i_done & d_done}, 32'h0);
        chk("bus_idle_at_done", {31'b0, wb_cyc_o}, 32'h0);
        chk("sb_nonempty", {31'b0, sb.size() != 0}, 32'h1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("port", {31'b0, d_done}, {31'b0, e.pd});
          chk("err", {31'b0, d_done ? d_err : i_err}, {31'b0, e.err});
          chk("rdata", d_done ? d_rdata : i_rdata, e.rd);
        end
      end
    end
  end

  task automatic push_exp(input logic pd, input logic we, input logic eerr,
                          input logic [31:0] rd);
    exp_t e;
    if (!we && !eerr) begin
      if (pd) exp_d = rd;
      else    exp_i = rd;
    end
    e.pd  = pd;
    e.err = eerr;
    e.rd  = pd ? exp_d : exp_i;
    sb.push_back(e);
  endtask

  task automatic acc(input logic pd, input logic we, input logic [3:0] be,
                     input logic [31:0] a, input logic [31:0] wd,
                     input int w, input int mode, input logic [31:0] rd,
                     input logic eerr, input int estb);
    bit got;
    got = 1'b0;
    push_exp(pd, we, eerr, rd);
    s_wait = w;
    s_mode = mode;
    s_data = rd;
    @(negedge clk);
    #1;
    if (pd) begin
      d_req = 1'b1; d_we = we; d_be = be; d_addr = a; d_wdata = wd;
    end else begin
      i_req = 1'b1; i_addr = a;
    end
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      #1;
      if (pd ? d_done : i_done) got = 1'b1;
      else begin
        d_addr = ~a; d_wdata = ~wd; d_be = ~be; d_we = ~we; i_addr = ~a;
      end
    end
    chk("done_seen", {31'b0, got}, 32'h1);
    if (got) begin
      chk("pause_at_done", {31'b0, pause_o}, 32'h0);
      chk("stb_cycles", s_last, estb);
      chk("sel", {28'b0, s_sel}, {28'b0, pd ? be : 4'hF});
      chk("we", {31'b0, s_we}, {31'b0, pd & we});
      chk("adr", s_adr, a);
      if (pd && we) chk("wdat", s_dat, wd);
    end
    d_req = 1'b0;
    i_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int dn;
    int in;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_cyc", {31'b0, wb_cyc_o}, 32'h0);
    chk("rst_stb", {31'b0, wb_stb_o}, 32'h0);
    chk("rst_we", {31'b0, wb_we_o}, 32'h0);
    chk("rst_sel", {28'b0, wb_sel_o}, 32'h0);
    chk("rst_adr", wb_adr_o, 32'h0);
    chk("rst_dat", wb_dat_o, 32'h0);
    chk("rst_i_rdata", i_rdata, 32'h0);
    chk("rst_d_rdata", d_rdata, 32'h0);
    chk("rst_i_done", {31'b0, i_done}, 32'h0);
    chk("rst_d_done", {31'b0, d_done}, 32'h0);
    chk("rst_errs", {30'b0, i_err, d_err}, 32'h0);
    chk("rst_pause", {31'b0, pause_o}, 32'h0);
    rst = 1'b1;

    // contention from reset: D, then I, then D again
    s_wait = 0; s_mode = 0; s_data = 32'h0BAD_F00D;
    push_exp(1'b1, 1'b0, 1'b0, 32'h0BAD_F00D);
    push_exp(1'b0, 1'b0, 1'b0, 32'h0BAD_F00D);
    push_exp(1'b1, 1'b0, 1'b0, 32'h0BAD_F00D);
    @(negedge clk);
    #1;
    i_req = 1'b1; i_addr = 32'h0000_2000;
    d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h0000_1000;
    dn = 0;
    in = 0;
    for (int k = 0; k < 60 && (dn < 2 || in < 1); k++) begin
      @(negedge clk);
      #1;
      if (d_done) begin
        dn++;
        if (dn == 1) chk("pause_contend", {31'b0, pause_o}, 32'h1);
        if (dn == 2) d_req = 1'b0;
      end
      if (i_done) begin
        in++;
        i_req = 1'b0;
      end
    end
    chk("contend_d_count", dn, 2);
    chk("contend_i_count", in, 1);
    d_req = 1'b0;
    i_req = 1'b0;

    acc(1'b1, 1'b0, 4'hF, 32'h8000_0010, 32'h0, 0, 0, 32'hDEAD_BEEF, 1'b0, 1);
    acc(1'b1, 1'b1, 4'b0011, 32'h8000_0020, 32'h1234_5678, 3, 0,
        32'hCAFE_F00D, 1'b0, 4);
    acc(1'b0, 1'b0, 4'hF, 32'h0000_0100, 32'h0, 1, 0, 32'h0000_0013, 1'b0, 2);
    acc(1'b1, 1'b0, 4'hF, 32'h8000_0030, 32'h0, 0, 1, 32'h1111_1111, 1'b1, 4);
    acc(1'b1, 1'b0, 4'hF, 32'h8000_0040, 32'h0, 0, 2, 32'h2222_2222, 1'b1, 1);
    acc(1'b0, 1'b0, 4'hF, 32'h0000_0104, 32'h0, 2, 3, 32'h0000_0033, 1'b1, 3);

    // reset in the middle of a stalled fetch
    s_mode = 1;
    @(negedge clk);
    #1;
    i_req = 1'b1; i_addr = 32'h0000_0200;
    repeat (2) @(negedge clk);
    #1;
    chk("mid_stb_before_rst", {31'b0, wb_stb_o}, 32'h1);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_cyc", {31'b0, wb_cyc_o}, 32'h0);
    chk("mid_rst_stb", {31'b0, wb_stb_o}, 32'h0);
    chk("mid_rst_i_rdata", i_rdata, 32'h0);
    chk("mid_rst_d_rdata", d_rdata, 32'h0);
    exp_i = '0;
    exp_d = '0;
    repeat (2) begin
      @(negedge clk);
      #1;
      chk("mid_rst_no_done", {30'b0, i_done, d_done}, 32'h0);
    end
    rst = 1'b1;
    acc(1'b0, 1'b0, 4'hF, 32'h0000_0200, 32'h0, 0, 0, 32'h55AA_55AA, 1'b0, 1);

    repeat (3) @(negedge clk);
    #1;
    chk("sb_drained", sb.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
